// File: rtl/bullcow_pkg.sv
// Shared types and elaboration helpers for the Bulls & Cows match engine.
package bullcow_pkg;

  typedef enum logic [2:0] {
    StSetup       = 3'd0,
    StCheckSecret = 3'd1,
    StGuess       = 3'd2,
    StCheckGuess  = 3'd3,
    StWin         = 3'd4
`ifdef BULLCOW_ROUND_LIMIT_EN
    , StDraw      = 3'd5
`endif
  } state_e;

  function automatic int unsigned player_w(input int unsigned num_players);
    return (num_players > 1) ? $clog2(num_players) : 1;
  endfunction

  function automatic int unsigned count_w(input int unsigned num_digits);
    return $clog2(num_digits + 1);
  endfunction

  // Every digit of a legal code is distinct, so the alphabet must hold a full code.
  function automatic bit params_legal(input int unsigned num_players,
                                      input int unsigned num_digits,
                                      input int unsigned digit_max,
                                      input int unsigned max_rounds);
    return (num_players >= 2) && (num_digits >= 1) && (digit_max + 1 >= num_digits) &&
           (max_rounds >= 1);
  endfunction

endpackage

// File: rtl/bullcow_scorer.sv
// Combinational scorer: bulls/cows of guess against secret, plus legality of the guess.
module bullcow_scorer
  import bullcow_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned DIGIT_MAX  = 9,
  localparam int unsigned CW        = count_w(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] secret_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] guess_i,
  output logic [CW-1:0]                 bulls_o,
  output logic [CW-1:0]                 cows_o,
  output logic                          legal_o
);

  always_comb begin
    bulls_o = '0;
    cows_o  = '0;
    legal_o = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (32'(guess_i[i*DIGIT_W +: DIGIT_W]) > DIGIT_MAX) begin
        legal_o = 1'b0;
      end
      if (guess_i[i*DIGIT_W +: DIGIT_W] == secret_i[i*DIGIT_W +: DIGIT_W]) begin
        bulls_o = bulls_o + CW'(1);
      end
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (i != j) begin
          if (guess_i[i*DIGIT_W +: DIGIT_W] == guess_i[j*DIGIT_W +: DIGIT_W]) begin
            legal_o = 1'b0;
          end
          if (guess_i[i*DIGIT_W +: DIGIT_W] == secret_i[j*DIGIT_W +: DIGIT_W]) begin
            cows_o = cows_o + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/bullcow_match_engine.sv
// N-player Bulls & Cows match controller with persistent saturating scores.
// Optional round limit with DRAW state: define BULLCOW_ROUND_LIMIT_EN.
module bullcow_match_engine
  import bullcow_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned DIGIT_MAX   = 9,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned MAX_ROUNDS  = 10,
  localparam int unsigned PW         = player_w(NUM_PLAYERS),
  localparam int unsigned CW         = count_w(NUM_DIGITS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enter,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  code_in,
  output logic [2:0]                     game_state,
  output logic [PW-1:0]                  active_player,
  output logic [CW-1:0]                  bulls,
  output logic [CW-1:0]                  cows,
  output logic                           result_valid,
  output logic                           input_error,
  output logic [PW-1:0]                  winner,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [15:0]                    round_count
);

  localparam int unsigned CodeW = NUM_DIGITS * DIGIT_W;

  if (!params_legal(NUM_PLAYERS, NUM_DIGITS, DIGIT_MAX, MAX_ROUNDS)) begin : gen_param_check
    $fatal(1, "bullcow_match_engine: illegal parameter set");
  end

  state_e                       state_q, state_d;
  logic [PW-1:0]                player_q, player_d;
  logic [CodeW-1:0]             code_q, code_d;
  logic [CodeW-1:0]             secret_q [NUM_PLAYERS];
  logic [CodeW-1:0]             secret_d [NUM_PLAYERS];
  logic [CW-1:0]                bulls_q, bulls_d, cows_q, cows_d;
  logic                         rv_q, rv_d, ie_q, ie_d;
  logic [PW-1:0]                winner_q, winner_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
  logic [15:0]                  round_q, round_d;

  logic          last_player;
  logic [PW-1:0] target;
  logic [CW-1:0] sc_bulls, sc_cows;
  logic          sc_legal;
  logic          sc_win;
  logic [SCORE_W-1:0] cur_score;
  logic          round_limit_hit;

  assign last_player = (player_q == PW'(NUM_PLAYERS - 1));
  assign target      = last_player ? '0 : player_q + PW'(1);
  assign sc_win      = (sc_bulls == CW'(NUM_DIGITS));
  assign cur_score   = scores_q[player_q*SCORE_W +: SCORE_W];

`ifdef BULLCOW_ROUND_LIMIT_EN
  assign round_limit_hit = last_player && ((round_q + 16'd1) == 16'(MAX_ROUNDS));
`else
  assign round_limit_hit = 1'b0;
`endif

  // In CHECK_SECRET only the legality of code_q matters; the secret port is don't-care.
  bullcow_scorer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .DIGIT_MAX  (DIGIT_MAX)
  ) u_scorer (
    .secret_i (secret_q[target]),
    .guess_i  (code_q),
    .bulls_o  (sc_bulls),
    .cows_o   (sc_cows),
    .legal_o  (sc_legal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StSetup;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSetup: if (enter) state_d = StCheckSecret;
      StCheckSecret: begin
        if (sc_legal && last_player) state_d = StGuess;
        else                         state_d = StSetup;
      end
      StGuess: if (enter) state_d = StCheckGuess;
      StCheckGuess: begin
        if (!sc_legal)            state_d = StGuess;
        else if (sc_win)          state_d = StWin;
`ifdef BULLCOW_ROUND_LIMIT_EN
        else if (round_limit_hit) state_d = StDraw;
`endif
        else                      state_d = StGuess;
      end
      StWin: if (enter) state_d = StSetup;
`ifdef BULLCOW_ROUND_LIMIT_EN
      StDraw: if (enter) state_d = StSetup;
`endif
      default: state_d = StSetup;
    endcase
  end

  always_comb begin
    player_d = player_q;
    code_d   = code_q;
    secret_d = secret_q;
    bulls_d  = bulls_q;
    cows_d   = cows_q;
    rv_d     = 1'b0;
    ie_d     = 1'b0;
    winner_d = winner_q;
    scores_d = scores_q;
    round_d  = round_q;
    unique case (state_q)
      StSetup, StGuess: if (enter) code_d = code_in;
      StCheckSecret: begin
        if (!sc_legal) begin
          ie_d = 1'b1;
        end else begin
          secret_d[player_q] = code_q;
          player_d           = target;
        end
      end
      StCheckGuess: begin
        if (!sc_legal) begin
          ie_d = 1'b1;
        end else begin
          bulls_d = sc_bulls;
          cows_d  = sc_cows;
          rv_d    = 1'b1;
          if (sc_win) begin
            winner_d = player_q;
            if (cur_score != '1) begin
              scores_d[player_q*SCORE_W +: SCORE_W] = cur_score + SCORE_W'(1);
            end
          end else begin
            player_d = target;
            if (last_player) round_d = round_q + 16'd1;
          end
        end
      end
      default: begin
        // WIN and DRAW: a new match keeps scores but forgets everything else.
        if (enter) begin
          player_d = '0;
          round_d  = '0;
          for (int i = 0; i < NUM_PLAYERS; i++) secret_d[i] = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      player_q <= '0;
      code_q   <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) secret_q[i] <= '0;
      bulls_q  <= '0;
      cows_q   <= '0;
      rv_q     <= 1'b0;
      ie_q     <= 1'b0;
      winner_q <= '0;
      scores_q <= '0;
      round_q  <= '0;
    end else begin
      player_q <= player_d;
      code_q   <= code_d;
      secret_q <= secret_d;
      bulls_q  <= bulls_d;
      cows_q   <= cows_d;
      rv_q     <= rv_d;
      ie_q     <= ie_d;
      winner_q <= winner_d;
      scores_q <= scores_d;
      round_q  <= round_d;
    end
  end

  assign game_state    = state_q;
  assign active_player = player_q;
  assign bulls         = bulls_q;
  assign cows          = cows_q;
  assign result_valid  = rv_q;
  assign input_error   = ie_q;
  assign winner        = winner_q;
  assign scores        = scores_q;
  assign round_count   = round_q;

endmodule
